serial_pattern_detector: RTL

- Parametrised successor of the team's fixed serial-line recognisers.
- Watches a serial bit stream (LINEA, qualified by LINEA_VLD) and pulses U when the last PAT_W accepted bits equal a runtime-programmable pattern under a don't-care mask.
- Supports overlapping and non-overlapping detection and keeps an optional saturating match counter.
- Sits between the serial line front-end and the control FSMs that consume U.

---
 rtl/serial_pattern_detector_if.sv | 31 +++
 rtl/serial_pattern_detector.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector_if.sv
// Serial pattern detector bus.
// Groups the serial line, configuration and result signals of
// serial_pattern_detector.
//   master : front-end / control side (drives LINEA, LINEA_VLD, CFG_WE,
//            PAT_IN, MASK_IN, OVERLAP; receives U, SYNCED, MATCH_CNT, CNT_SAT)
//   slave  : detector side (the reverse directions)
interface serial_pattern_detector_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             LINEA;
  logic             LINEA_VLD;
  logic             CFG_WE;
  logic [PAT_W-1:0] PAT_IN;
  logic [PAT_W-1:0] MASK_IN;
  logic             OVERLAP;
  logic             U;
  logic             SYNCED;
  logic [CNT_W-1:0] MATCH_CNT;
  logic             CNT_SAT;

  modport master (
    output LINEA, LINEA_VLD, CFG_WE, PAT_IN, MASK_IN, OVERLAP,
    input  U, SYNCED, MATCH_CNT, CNT_SAT
  );

  modport slave (
    input  LINEA, LINEA_VLD, CFG_WE, PAT_IN, MASK_IN, OVERLAP,
    output U, SYNCED, MATCH_CNT, CNT_SAT
  );
endinterface

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector.
// Shifts in bits of LINEA qualified by LINEA_VLD and pulses U one cycle after
// an accepted bit that completes a window matching PAT under MASK
// (MASK bit 1 = compare, 0 = don't care). PAT bit PAT_W-1 is the oldest bit.
// Ports:
//   CLOCK  rising-edge clock
//   RESET  synchronous active-high reset
//   sp     serial_pattern_detector_if.slave:
//          LINEA/LINEA_VLD serial input, CFG_WE/PAT_IN/MASK_IN reconfiguration
//          (also restarts detection), OVERLAP detection mode, U match pulse,
//          SYNCED window-full flag, MATCH_CNT/CNT_SAT saturating match count.
// Optional feature: define SPD_MATCH_CNT_EN to build the match counter;
// otherwise MATCH_CNT and CNT_SAT are tied to zero.
module serial_pattern_detector #(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1001,
  parameter int unsigned      CNT_W       = 8
) (
  input logic                       CLOCK,
  input logic                       RESET,
  serial_pattern_detector_if.slave  sp
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  typedef enum logic {
    FILL = 1'b0,
    HUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             u_q, u_d;

  logic [PAT_W-1:0] sr_n;
  logic             hit;
  logic             eval;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    pat_d      = pat_q;
    mask_d     = mask_q;
    fill_cnt_d = fill_cnt_q;
    u_d        = 1'b0;
    eval       = 1'b0;

    sr_n = (sr_q << 1) | {{(PAT_W-1){1'b0}}, sp.LINEA};
    hit  = ((sr_n ^ pat_q) & mask_q) == '0;

    if (sp.CFG_WE) begin
      pat_d      = sp.PAT_IN;
      mask_d     = sp.MASK_IN;
      sr_d       = '0;
      fill_cnt_d = '0;
      state_d    = FILL;
    end else if (sp.LINEA_VLD) begin
      sr_d = sr_n;
      unique case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + FW'(1);
          // The bit that completes the window is judged like a HUNT bit, so
          // a non-overlapping hit here sends us straight back to FILL.
          if (fill_cnt_d == FILL_FULL) begin
            eval    = 1'b1;
            state_d = HUNT;
          end
        end
        HUNT: eval = 1'b1;
        default: ;
      endcase
      if (eval && hit) begin
        u_d = 1'b1;
        if (!sp.OVERLAP) begin
          fill_cnt_d = '0;
          state_d    = FILL;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= FILL;
      sr_q       <= '0;
      pat_q      <= DEFAULT_PAT;
      mask_q     <= '1;
      fill_cnt_q <= '0;
      u_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      pat_q      <= pat_d;
      mask_q     <= mask_d;
      fill_cnt_q <= fill_cnt_d;
      u_q        <= u_d;
    end
  end

  assign sp.U      = u_q;
  assign sp.SYNCED = (state_q == HUNT);

`ifdef SPD_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (u_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sp.MATCH_CNT = cnt_q;
  assign sp.CNT_SAT   = &cnt_q;
`else
  assign sp.MATCH_CNT = {CNT_W{1'b0}};
  assign sp.CNT_SAT   = 1'b0;
`endif

endmodule
